// File: rtl/fifo_word_packer_if.sv
// rtl/fifo_word_packer_if.sv - byte-stream input and output-FIFO write bundle for fifo_word_packer
// master = chip-side source and FIFO model, slave = the packer.
interface fifo_word_packer_if;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        FIFO_full;
   logic [31:0] FIFO_IN;
   logic        FIFO_wen;

   modport master (
      output byte_in, byte_valid, FIFO_full,
      input  byte_ready, FIFO_IN, FIFO_wen
   );

   modport slave (
      input  byte_in, byte_valid, FIFO_full,
      output byte_ready, FIFO_IN, FIFO_wen
   );
endinterface

// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs a byte stream into little-endian 32-bit words for the output FIFO
// Optional WORD_TAG_EN: 3 data bytes per word, [31:24] carries word_count[7:0] as a sequence tag.
module fifo_word_packer #(
   parameter logic [7:0] PAD_BYTE = 8'h00,
   parameter int         CNT_W    = 16
) (
   input  logic              CLK,
   input  logic              rst_n,
   fifo_word_packer_if.slave bus,
   input  logic              flush,
   output logic              flush_done,
   output logic              busy,
   output logic [CNT_W-1:0]  word_count
);
`ifdef WORD_TAG_EN
   localparam int LANES = 3;
`else
   localparam int LANES = 4;
`endif
   localparam int DATA_W = 8 * LANES;

   typedef enum logic [1:0] {COLLECT, HOLD, WRITE} state_t;

   state_t            state;
   logic [1:0]        lane;
   logic [DATA_W-1:0] word_buf;
   logic              flush_pend;
   logic              from_flush;
   logic              accept;
   logic              completes;
   logic [2:0]        filled;
   logic [DATA_W-1:0] staged;
   logic [31:0]       out_word;

   assign bus.byte_ready = (state == COLLECT);
   assign busy           = (state != COLLECT) || (lane != 2'd0);
   assign accept         = bus.byte_valid && (state == COLLECT);
   assign filled         = {1'b0, lane} + {2'b00, accept};
   assign completes      = (filled == 3'(LANES));

   // Lanes beyond the last filled one are padded; harmless while collecting since later bytes overwrite them.
   always_comb begin
      staged = word_buf;
      if (accept) staged[{lane, 3'b000} +: 8] = bus.byte_in;
      for (int i = 0; i < LANES; i++) begin
         if (3'(i) >= filled) staged[8*i +: 8] = PAD_BYTE;
      end
   end

`ifdef WORD_TAG_EN
   assign out_word = {word_count[7:0], word_buf};
`else
   assign out_word = word_buf;
`endif

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state        <= COLLECT;
         lane         <= 2'd0;
         word_buf     <= '0;
         flush_pend   <= 1'b0;
         from_flush   <= 1'b0;
         bus.FIFO_IN  <= '0;
         bus.FIFO_wen <= 1'b0;
         flush_done   <= 1'b0;
         word_count   <= '0;
      end else begin
         flush_done <= 1'b0;
         case (state)
            COLLECT: begin
               // A flush latched during HOLD/WRITE retires here with nothing left to write.
               if (flush_pend) begin
                  flush_done <= 1'b1;
                  flush_pend <= 1'b0;
               end
               if (accept) begin
                  word_buf <= staged;
                  lane     <= lane + 2'd1;
                  if (completes || flush) begin
                     state      <= HOLD;
                     from_flush <= flush;
                  end
               end else if (flush) begin
                  if (lane != 2'd0) begin
                     word_buf   <= staged;
                     state      <= HOLD;
                     from_flush <= 1'b1;
                  end else begin
                     flush_done <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (flush) flush_pend <= 1'b1;
               if (!bus.FIFO_full) begin
                  state        <= WRITE;
                  bus.FIFO_wen <= 1'b1;
                  bus.FIFO_IN  <= out_word;
               end
            end
            WRITE: begin
               if (flush) flush_pend <= 1'b1;
               bus.FIFO_wen <= 1'b0;
               word_count   <= word_count + CNT_W'(1);
               lane         <= 2'd0;
               state        <= COLLECT;
               flush_done   <= from_flush;
               from_flush   <= 1'b0;
            end
            default: state <= COLLECT;
         endcase
      end
   end
endmodule
